// File: rtl/cache_pkg.sv
// Shared geometry, FSM state type and address-split helper for the line cache.
// The CACHE_STATS_EN build option lives in line_cache; nothing here depends on it.
package cache_pkg;

    localparam int unsigned LINE_SIZE        = 8;
    localparam int unsigned SET_SIZE         = 8;
    localparam int unsigned TAG_ADDR_LEN_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } cache_state_t;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] set;
        logic [31:0] word;
    } addr_fields_t;

    // Byte address -> {tag,set,word}; addr[1:0] and bits above the tag are dropped.
    function automatic addr_fields_t split_addr(input logic [31:0] addr,
                                                input int unsigned line_len,
                                                input int unsigned set_len,
                                                input int unsigned tag_len);
        addr_fields_t f;
        logic [31:0]  wa;
        wa     = addr >> 2;
        f.word = wa & ((32'd1 << line_len) - 32'd1);
        f.set  = (wa >> line_len) & ((32'd1 << set_len) - 32'd1);
        f.tag  = (wa >> (line_len + set_len)) & ((32'd1 << tag_len) - 32'd1);
        return f;
    endfunction

endpackage

// File: rtl/cache_tag_ram.sv
// Per-set valid/dirty/tag storage: one combinational read port, one write port.
// Valid and dirty clear on reset; tags are don't-care until their valid bit is set.
module cache_tag_ram
    import cache_pkg::*;
#(
    parameter int unsigned SET_ADDR_LEN = 3,
    parameter int unsigned TAG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_ADDR_LEN-1:0] rd_set_i,
    output logic                    rd_valid_o,
    output logic                    rd_dirty_o,
    output logic [TAG_ADDR_LEN-1:0] rd_tag_o,
    input  logic                    we_i,
    input  logic [SET_ADDR_LEN-1:0] wr_set_i,
    input  logic [TAG_ADDR_LEN-1:0] wr_tag_i,
    input  logic                    wr_valid_i,
    input  logic                    wr_dirty_i
);

    localparam int unsigned SETS = 1 << SET_ADDR_LEN;

    logic [SETS-1:0]         valid_q;
    logic [SETS-1:0]         dirty_q;
    logic [TAG_ADDR_LEN-1:0] tag_q [SETS];

    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[wr_set_i] <= wr_valid_i;
            dirty_q[wr_set_i] <= wr_dirty_i;
        end
    end

    // NOTE: storage arrays get no reset; valid_q qualifies their contents.
    always_ff @(posedge clk) begin
        if (we_i) tag_q[wr_set_i] <= wr_tag_i;
    end

    assign rd_valid_o = valid_q[rd_set_i];
    assign rd_dirty_o = dirty_q[rd_set_i];
    assign rd_tag_o   = tag_q[rd_set_i];

endmodule

// File: rtl/line_cache.sv
// Direct-mapped write-back, write-allocate cache; initiates line transfers to main_mem.
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt outputs.
module line_cache
    import cache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = $clog2(LINE_SIZE),
    parameter int unsigned SET_ADDR_LEN  = $clog2(SET_SIZE),
    parameter int unsigned TAG_ADDR_LEN  = TAG_ADDR_LEN_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rd_req,
    input  logic                                  wr_req,
    input  logic [31:0]                           addr,
    input  logic [31:0]                           wr_data,
    output logic [31:0]                           rd_data,
    output logic                                  miss,
    input  logic                                  mem_gnt,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]  mem_addr,
    output logic                                  mem_rd_req,
    input  logic [32*((1<<LINE_ADDR_LEN)+1)-1:0]  mem_rd_line,
    output logic                                  mem_wr_req,
    output logic [32*((1<<LINE_ADDR_LEN)+1)-1:0]  mem_wr_line
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                           hit_cnt,
    output logic [31:0]                           miss_cnt
`endif
);

    localparam int unsigned LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS       = 1 << SET_ADDR_LEN;
    localparam int unsigned LINE_W     = 32 * (LINE_WORDS + 1);
    localparam int unsigned MADDR_W    = TAG_ADDR_LEN + SET_ADDR_LEN;

    cache_state_t state_q, state_d;

    addr_fields_t              fields;
    logic [TAG_ADDR_LEN-1:0]   cur_tag, req_tag_q, req_tag_d, tag_rd, tag_wr_tag;
    logic [SET_ADDR_LEN-1:0]   cur_set, req_set_q, req_set_d, tag_wr_set;
    logic [LINE_ADDR_LEN-1:0]  cur_word;
    logic                      req, hit, tag_valid, tag_dirty;
    logic                      tag_we, tag_wr_valid, tag_wr_dirty, word_we, fill_en;
    logic [31:0]               rd_data_q, rd_data_d;
    logic [MADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                      mem_rd_req_q, mem_rd_req_d, mem_wr_req_q, mem_wr_req_d;
    logic [LINE_W-1:0]         mem_wr_line_q, mem_wr_line_d, victim_line;
    logic [31:0]               data_q [SETS][LINE_WORDS];
    logic                      unused_bits;

    assign fields   = split_addr(addr, LINE_ADDR_LEN, SET_ADDR_LEN, TAG_ADDR_LEN);
    assign cur_tag  = fields.tag[TAG_ADDR_LEN-1:0];
    assign cur_set  = fields.set[SET_ADDR_LEN-1:0];
    assign cur_word = fields.word[LINE_ADDR_LEN-1:0];
    assign unused_bits = ^{fields.tag[31:TAG_ADDR_LEN], fields.set[31:SET_ADDR_LEN],
                           fields.word[31:LINE_ADDR_LEN], mem_rd_line[LINE_W-1 -: 32]};

    cache_tag_ram #(
        .SET_ADDR_LEN (SET_ADDR_LEN),
        .TAG_ADDR_LEN (TAG_ADDR_LEN)
    ) u_tag_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_set_i   (cur_set),
        .rd_valid_o (tag_valid),
        .rd_dirty_o (tag_dirty),
        .rd_tag_o   (tag_rd),
        .we_i       (tag_we),
        .wr_set_i   (tag_wr_set),
        .wr_tag_i   (tag_wr_tag),
        .wr_valid_i (tag_wr_valid),
        .wr_dirty_i (tag_wr_dirty)
    );

    assign req  = rd_req | wr_req;
    assign hit  = tag_valid & (tag_rd == cur_tag);
    assign miss = req & ((state_q != IDLE) | ~hit);

    always_comb begin
        victim_line = '0;
        for (int w = 0; w < LINE_WORDS; w++) victim_line[32*w +: 32] = data_q[cur_set][w];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (req && !hit) state_d = (tag_valid && tag_dirty) ? SWAP_OUT : SWAP_IN;
            SWAP_OUT:   if (mem_gnt) state_d = SWAP_IN;
            SWAP_IN:    if (mem_gnt) state_d = SWAP_IN_OK;
            SWAP_IN_OK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: every always_comb output is defaulted first so no path infers a latch.
    always_comb begin
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_req_d  = mem_rd_req_q;
        mem_wr_req_d  = mem_wr_req_q;
        mem_wr_line_d = mem_wr_line_q;
        req_tag_d     = req_tag_q;
        req_set_d     = req_set_q;
        tag_we        = 1'b0;
        tag_wr_set    = cur_set;
        tag_wr_tag    = cur_tag;
        tag_wr_valid  = 1'b1;
        tag_wr_dirty  = 1'b1;
        word_we       = 1'b0;
        fill_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    if (rd_req) begin
                        rd_data_d = data_q[cur_set][cur_word];
                    end else begin
                        word_we = 1'b1;
                        tag_we  = 1'b1;
                    end
                end else if (req) begin
                    req_tag_d = cur_tag;
                    req_set_d = cur_set;
                    if (tag_valid && tag_dirty) begin
                        mem_addr_d    = {tag_rd, cur_set};
                        mem_wr_line_d = victim_line;
                        mem_wr_req_d  = 1'b1;
                    end else begin
                        mem_addr_d   = {cur_tag, cur_set};
                        mem_rd_req_d = 1'b1;
                    end
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) begin
                    mem_wr_req_d = 1'b0;
                    mem_addr_d   = {req_tag_q, req_set_q};
                    mem_rd_req_d = 1'b1;
                end
            end
            SWAP_IN: begin
                if (mem_gnt) mem_rd_req_d = 1'b0;
            end
            SWAP_IN_OK: begin
                fill_en      = 1'b1;
                tag_we       = 1'b1;
                tag_wr_set   = req_set_q;
                tag_wr_tag   = req_tag_q;
                tag_wr_dirty = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q     <= '0;
            mem_addr_q    <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
            mem_wr_line_q <= '0;
            req_tag_q     <= '0;
            req_set_q     <= '0;
        end else begin
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_line_q <= mem_wr_line_d;
            req_tag_q     <= req_tag_d;
            req_set_q     <= req_set_d;
        end
    end

    // Refill data is only on mem_rd_line during SWAP_IN_OK, one cycle after gnt.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            for (int w = 0; w < LINE_WORDS; w++) data_q[req_set_q][w] <= mem_rd_line[32*w +: 32];
        end else if (word_we) begin
            data_q[cur_set][cur_word] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_wr_line = mem_wr_line_q;

`ifdef CACHE_STATS_EN
    logic        retry_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // retry_q marks the first IDLE cycle after a refill so the replayed request is not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == SWAP_IN_OK) retry_q <= 1'b1;
            else if (state_q == IDLE)  retry_q <= 1'b0;
            if (state_q == IDLE && req && hit && !retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && state_d != IDLE)        miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
